// File: rtl/axis_skid_cache_pkg.sv
// ---------------------------------------------------------------------------
// axis_skid_cache_pkg
// Shared types and default widths for the axis_skid_cache register slice.
//   state_t     : occupancy of the slice (EMPTY, ONE, FULL), 2-bit encoding
//   DSIZE_DEF   : default tdata width
//   CSIZE_DEF   : default width of the output beat counter
//   USIZE_DEF   : default tuser width (AXIS_SKID_CACHE_TUSER_EN builds only)
// ---------------------------------------------------------------------------
package axis_skid_cache_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int DSIZE_DEF = 8;
   localparam int CSIZE_DEF = 16;
   localparam int USIZE_DEF = 1;

endpackage

// File: rtl/axis_skid_cache_reg.sv
// ---------------------------------------------------------------------------
// axis_skid_cache_reg
// One payload register of the skid buffer (tdata + tlast [+ tuser], packed
// into a single vector by the parent). Used twice: main and skid entry.
//   aclk    in  : clock
//   aresetn in  : asynchronous active-low reset, clears the payload to 0
//   load    in  : capture d on the next rising edge (already clock-enabled)
//   d       in  : payload to capture
//   q       out : stored payload
// ---------------------------------------------------------------------------
module axis_skid_cache_reg
   import axis_skid_cache_pkg::*;
#(
   parameter int W = DSIZE_DEF + 1
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Payload holds its value unless the parent explicitly loads it, which is
   // what keeps the output stable while the consumer stalls.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/axis_skid_cache.sv
// ---------------------------------------------------------------------------
// axis_skid_cache
// Two-entry AXI-Stream register slice. Forward (tdata/tlast/tvalid) and
// backward (tready) paths are both registered, 1 beat/clock sustained.
// Also reports the index of the current output beat within its packet.
//   aclk, aresetn, aclken       : clock, async active-low reset, clock enable
//   s_axis_tdata/tvalid/tlast   : upstream beat
//   s_axis_tready               : upstream ready (registered)
//   m_axis_tdata/tvalid/tlast   : downstream beat (registered)
//   m_axis_tready               : downstream ready
//   m_axis_tcnt                 : beat index in current output packet
// Optional: define AXIS_SKID_CACHE_TUSER_EN to add s_axis_tuser/m_axis_tuser,
// carried alongside tdata through both entries.
// ---------------------------------------------------------------------------
module axis_skid_cache
   import axis_skid_cache_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int CSIZE = CSIZE_DEF,
   parameter int USIZE = USIZE_DEF
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             aclken,
   input  logic [DSIZE-1:0] s_axis_tdata,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tlast,
`ifdef AXIS_SKID_CACHE_TUSER_EN
   input  logic [USIZE-1:0] s_axis_tuser,
   output logic [USIZE-1:0] m_axis_tuser,
`endif
   output logic             s_axis_tready,
   output logic [DSIZE-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   output logic             m_axis_tlast,
   input  logic             m_axis_tready,
   output logic [CSIZE-1:0] m_axis_tcnt
);

`ifdef AXIS_SKID_CACHE_TUSER_EN
   localparam bit TUSER_EN = 1'b1;
`else
   localparam bit TUSER_EN = 1'b0;
`endif
   localparam int PW = DSIZE + 1 + (TUSER_EN ? USIZE : 0);

   state_t           state_q;
   state_t           state_d;
   logic             tready_q;
   logic             tvalid_q;
   logic [CSIZE-1:0] cnt_q;
   logic             accept;
   logic             xfer;
   logic             load_main;
   logic             load_skid;
   logic             main_from_skid;
   logic [PW-1:0]    in_payload;
   logic [PW-1:0]    main_d;
   logic [PW-1:0]    main_q;
   logic [PW-1:0]    skid_q;

   // Both handshakes are qualified by aclken so a disabled clock freezes
   // every register below without extra gating.
   assign accept = s_axis_tvalid & tready_q & aclken;
   assign xfer   = tvalid_q & m_axis_tready & aclken;

`ifdef AXIS_SKID_CACHE_TUSER_EN
   assign in_payload = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
`else
   assign in_payload = {s_axis_tlast, s_axis_tdata};
`endif

   // Main entry refills from skid when draining FULL, otherwise from input.
   assign main_d = main_from_skid ? skid_q : in_payload;

   axis_skid_cache_reg #(.W(PW)) u_main (
      .aclk    (aclk),
      .aresetn (aresetn),
      .load    (load_main),
      .d       (main_d),
      .q       (main_q)
   );

   axis_skid_cache_reg #(.W(PW)) u_skid (
      .aclk    (aclk),
      .aresetn (aresetn),
      .load    (load_skid),
      .d       (in_payload),
      .q       (skid_q)
   );

   // Occupancy FSM: decides where an accepted beat lands and when the skid
   // entry drains into main. tready is only ever derived from the next
   // state, so it never sees m_axis_tready combinationally at the output.
   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               load_main = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (accept && xfer) begin
               load_main = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_d   = FULL;
            end else if (xfer) begin
               state_d   = EMPTY;
            end
         end
         FULL: begin
            if (xfer) begin
               load_main      = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // State plus registered handshake outputs. tready comes up one clock
   // after reset release because it is only refreshed on enabled edges.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= EMPTY;
         tready_q <= 1'b0;
         tvalid_q <= 1'b0;
      end else if (aclken) begin
         state_q  <= state_d;
         tready_q <= (state_d != FULL);
         tvalid_q <= (state_d != EMPTY);
      end
   end

   // Beat index of the presented output; restarts after a tlast transfer
   // and wraps naturally at 2^CSIZE.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q <= '0;
      end else if (xfer) begin
         if (m_axis_tlast) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CSIZE'(1);
         end
      end
   end

   assign s_axis_tready = tready_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = main_q[DSIZE-1:0];
   assign m_axis_tlast  = main_q[DSIZE];
   assign m_axis_tcnt   = cnt_q;
`ifdef AXIS_SKID_CACHE_TUSER_EN
   assign m_axis_tuser  = main_q[DSIZE+1 +: USIZE];
`endif

endmodule

// File: tb/tb_axis_skid_cache.sv
// ---------------------------------------------------------------------------
// tb_axis_skid_cache
// Self-checking bench for axis_skid_cache (default build, no tuser).
// Accepted input beats are pushed into a scoreboard with the packet index
// they must carry; a monitor pops and compares whenever the output
// transfers, and checks every cycle that tready/tvalid match the number of
// beats held (accepted minus delivered).
// ---------------------------------------------------------------------------
module tb_axis_skid_cache;

   typedef struct {
      logic [7:0]  data;
      logic        last;
      logic [15:0] cnt;
   } beat_t;

   logic        aclk;
   logic        aresetn;
   logic        aclken;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic [15:0] m_axis_tcnt;

   beat_t       sb[$];
   logic [15:0] in_idx;
   int          n_cmp;
   int          n_bad;
   int          n_push;
   int          n_out;
   bit          mon_on;

   axis_skid_cache #(.DSIZE(8), .CSIZE(16), .USIZE(1)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .aclken        (aclken),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .m_axis_tcnt   (m_axis_tcnt)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Holds the given input values for one clock; returns just after the edge.
   task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic l,
                                 input logic mr, input logic en);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      m_axis_tready = mr;
      aclken        = en;
      @(posedge aclk);
      #1;
   endtask

   // Offers one beat and keeps it valid until the slice takes it.
   task automatic send_beat(input logic [7:0] d, input logic l);
      bit done;
      done          = 1'b0;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge aclk);
         if (s_axis_tready && aclken) done = 1'b1;
         @(posedge aclk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      check_output("send_accept", 32'(done), 32'd1);
   endtask

   // Lets the slice empty out with the consumer always ready.
   task automatic drain();
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      aclken        = 1'b1;
      for (int i = 0; i < 50 && sb.size() != 0; i++) begin
         @(posedge aclk);
         #1;
      end
      @(posedge aclk);
      #1;
      check_output("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Reference model input side: each beat that will be accepted at the
   // coming edge gets its position within its packet.
   always @(negedge aclk) begin
      #1;
      if (mon_on && aresetn && s_axis_tvalid && s_axis_tready && aclken) begin
         sb.push_back('{data: s_axis_tdata, last: s_axis_tlast, cnt: in_idx});
         n_push++;
         in_idx = s_axis_tlast ? 16'd0 : in_idx + 16'd1;
      end
   end

   // Monitor: occupancy-derived flags every cycle; presented beat against
   // the scoreboard head whenever valid, popping on an enabled transfer.
   always @(negedge aclk) begin
      int    sz;
      beat_t exp_beat;
      if (mon_on && aresetn) begin
         sz = sb.size();
         check_output("s_tready_vs_occupancy", 32'(s_axis_tready), 32'(sz < 2));
         check_output("m_tvalid_vs_occupancy", 32'(m_axis_tvalid), 32'(sz > 0));
         if (m_axis_tvalid) begin
            if (sz == 0) begin
               n_cmp++;
               n_bad++;
               $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", m_axis_tdata);
            end else begin
               exp_beat = sb[0];
               check_output("m_tdata", 32'(m_axis_tdata), 32'(exp_beat.data));
               check_output("m_tlast", 32'(m_axis_tlast), 32'(exp_beat.last));
               check_output("m_tcnt",  32'(m_axis_tcnt),  32'(exp_beat.cnt));
               if (m_axis_tready && aclken) begin
                  exp_beat = sb.pop_front();
                  n_out++;
               end
            end
         end
      end
   end

   initial begin
      int out_before;
      int target;
      n_cmp  = 0;
      n_bad  = 0;
      n_push = 0;
      n_out  = 0;
      mon_on = 1'b0;
      in_idx = 16'd0;
      aresetn       = 1'b0;
      aclken        = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'd0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b0;

      // Reset then idle
      #1;
      check_output("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check_output("rst_s_tready", 32'(s_axis_tready), 32'd0);
      check_output("rst_m_tcnt",   32'(m_axis_tcnt),   32'd0);
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(negedge aclk);
      check_output("release_cycle_s_tready", 32'(s_axis_tready), 32'd0);
      @(negedge aclk);
      check_output("idle_s_tready", 32'(s_axis_tready), 32'd1);
      check_output("idle_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check_output("idle_m_tcnt",   32'(m_axis_tcnt),   32'd0);
      mon_on = 1'b1;
      @(posedge aclk);
      #1;

      // Streaming packet 0x01..0x08, back-to-back with consumer ready
      m_axis_tready = 1'b1;
      out_before = n_out;
      for (int i = 1; i <= 8; i++) send_beat(8'(i), (i == 8));
      drain();
      check_output("stream_beats_out", 32'(n_out - out_before), 32'd8);

      // Backpressure into FULL; 0xA2 must wait
      m_axis_tready = 1'b0;
      send_beat(8'hA0, 1'b0);
      send_beat(8'hA1, 1'b0);
      s_axis_tdata  = 8'hA2;
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      repeat (2) begin
         @(posedge aclk);
         #1;
      end
      @(negedge aclk);
      check_output("full_s_tready", 32'(s_axis_tready), 32'd0);
      check_output("full_hold_data", 32'(m_axis_tdata), 32'hA0);
      check_output("full_push_count", 32'(sb.size()), 32'd2);
      @(posedge aclk);
      #1;
      m_axis_tready = 1'b1;
      send_beat(8'hA2, 1'b1);
      drain();

      // aclken gating mid-packet with valid and ready both high
      send_beat(8'h31, 1'b0);
      send_beat(8'h32, 1'b0);
      s_axis_tdata  = 8'h33;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      aclken        = 1'b0;
      repeat (5) begin
         @(negedge aclk);
         check_output("gated_m_tdata", 32'(m_axis_tdata), 32'h32);
         check_output("gated_m_tcnt",  32'(m_axis_tcnt),  32'd1);
         @(posedge aclk);
         #1;
      end
      aclken = 1'b1;
      send_beat(8'h33, 1'b0);
      send_beat(8'h34, 1'b1);
      drain();

      // Random valid/ready (and occasional clock-enable drop), 1000 beats
      target = n_push + 1000;
      for (int c = 0; c < 20000 && n_push < target; c++) begin
         apply_stimulus($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 7) == 0,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0);
      end
      check_output("random_beats_accepted", 32'(n_push >= target), 32'd1);
      drain();

      // Async reset while FULL, mid-packet
      m_axis_tready = 1'b1;
      send_beat(8'h50, 1'b1);
      send_beat(8'h51, 1'b0);
      send_beat(8'h52, 1'b0);
      send_beat(8'h53, 1'b0);
      m_axis_tready = 1'b0;
      send_beat(8'h54, 1'b0);
      @(negedge aclk);
      check_output("pre_reset_m_tcnt", 32'(m_axis_tcnt), 32'd2);
      #2;
      mon_on  = 1'b0;
      aresetn = 1'b0;
      #1;
      check_output("async_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check_output("async_rst_s_tready", 32'(s_axis_tready), 32'd0);
      check_output("async_rst_m_tcnt",   32'(m_axis_tcnt),   32'd0);
      check_output("async_rst_m_tdata",  32'(m_axis_tdata),  32'd0);
      sb.delete();
      in_idx = 16'd0;
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      @(negedge aclk);
      check_output("post_rst_s_tready", 32'(s_axis_tready), 32'd1);
      mon_on = 1'b1;
      @(posedge aclk);
      #1;
      m_axis_tready = 1'b1;
      out_before = n_out;
      send_beat(8'h61, 1'b0);
      send_beat(8'h62, 1'b0);
      send_beat(8'h63, 1'b1);
      drain();
      check_output("post_rst_beats_out", 32'(n_out - out_before), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
